fu_seq_div: RTL and testbench

FU_SEQ_DIV -- requirements
Module: fu_seq_div

---
 rtl/fu_seq_div.sv | 116 +++++++++++
 tb/tb_fu_seq_div.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fu_seq_div.sv
// Sequential 32-bit integer divider: restoring radix-2, one quotient bit per cycle.
// Handles DIV/DIVU/REM/REMU including divide-by-zero and signed overflow.
module fu_seq_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        EN,
   input  logic [1:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        finish,
   output logic [31:0] res,
   output logic [1:0]  state_dbg
);

   // Handshake: EN is a one-cycle issue strobe accepted only while busy=0
   // (state IDLE); finish is a one-cycle completion pulse with res valid.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [32:0] rem;
   logic [31:0] quo;
   logic [31:0] dvs;
   logic [1:0]  op_q;
   logic        neg_q;
   logic        neg_r;

   logic        is_signed;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_abs;
   logic [31:0] b_abs;
   logic [32:0] sh;
   logic        ge;
   logic [32:0] rem_n;
   logic [31:0] quo_n;
   logic [31:0] q_fix;
   logic [31:0] r_fix;

   assign is_signed = ~op[0];
   assign a_neg     = is_signed & A[31];
   assign b_neg     = is_signed & B[31];
   assign a_abs     = a_neg ? (~A + 32'd1) : A;
   assign b_abs     = b_neg ? (~B + 32'd1) : B;

   // The dividend lives in quo and shifts into rem one bit per step.
   assign sh    = {rem[31:0], quo[31]};
   assign ge    = (sh >= {1'b0, dvs});
   assign rem_n = ge ? (sh - {1'b0, dvs}) : sh;
   assign quo_n = {quo[30:0], ge};

   assign q_fix = neg_q ? (~quo_n + 32'd1) : quo_n;
   assign r_fix = neg_r ? (~rem_n[31:0] + 32'd1) : rem_n[31:0];

   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= 6'd0;
         rem    <= 33'd0;
         quo    <= 32'd0;
         dvs    <= 32'd0;
         op_q   <= 2'd0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         busy   <= 1'b0;
         finish <= 1'b0;
         res    <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               finish <= 1'b0;
               if (EN) begin
                  op_q  <= op;
                  quo   <= a_abs;
                  dvs   <= b_abs;
                  rem   <= 33'd0;
                  cnt   <= 6'd0;
                  // A zero divisor yields all-ones quotient, never negated.
                  neg_q <= (a_neg ^ b_neg) & (B != 32'd0);
                  neg_r <= a_neg;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               rem <= rem_n;
               quo <= quo_n;
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31) begin
                  res    <= op_q[1] ? r_fix : q_fix;
                  finish <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               finish <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               finish <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fu_seq_div.sv
// Directed bench for fu_seq_div: hand-computed results, fixed latency, ignored
// re-issue, and reset abort.
module tb_fu_seq_div;

   logic        clk;
   logic        rst;
   logic        EN;
   logic [1:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        finish;
   logic [31:0] res;
   logic [1:0]  state_dbg;

   int vectors;
   int miscompares;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   fu_seq_div dut (
      .clk       (clk),
      .rst       (rst),
      .EN        (EN),
      .op        (op),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .finish    (finish),
      .res       (res),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one operation: EN high for exactly one sampling edge (k0).
   task automatic start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o;
      A  = a;
      B  = b;
      EN = 1'b1;
      @(posedge clk);
      #1;
      EN = 1'b0;
      A  = $urandom;
      B  = $urandom;
      op = 2'($urandom_range(0, 3));
   endtask

   // Called at k0+1ns. poke>0 re-pulses EN at that cycle offset while busy.
   // en_done=1 raises EN during the finish cycle (sampled as DONE returns to IDLE).
   task automatic wait_done(input string tag, input logic [31:0] exp, input int poke,
                            input bit en_done);
      int early;
      int late;
      early = 0;
      late  = 0;
      for (int i = 1; i <= 31; i++) begin
         if (finish) early++;
         if (i == poke) begin
            EN = 1'b1;
            A  = 32'd1000;
            B  = 32'd3;
            op = OP_DIVU;
         end else if (i == poke + 1) begin
            EN = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      if (finish) early++;
      chk({tag, "_early_finish"}, 32'(early), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_finish"}, {31'd0, finish}, 32'd1);
      chk({tag, "_res"}, res, exp);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_state_done"}, {30'd0, state_dbg}, 32'd2);
      if (en_done) EN = 1'b1;
      @(posedge clk);
      #1;
      EN = 1'b0;
      chk({tag, "_finish_low"}, {31'd0, finish}, 32'd0);
      chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
      chk({tag, "_res_hold"}, res, exp);
      if (en_done) begin
         @(posedge clk);
         #1;
         chk({tag, "_en_at_done_ignored"}, {31'd0, busy}, 32'd0);
      end
      for (int i = 0; i < 40; i++) begin
         if (finish) late++;
         @(posedge clk);
         #1;
      end
      chk({tag, "_no_extra_finish"}, 32'(late), 32'd0);
      chk({tag, "_res_held_idle"}, res, exp);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b0;
      EN  = 1'b0;
      op  = 2'b00;
      A   = 32'd0;
      B   = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_finish", {31'd0, finish}, 32'd0);
      chk("reset_res", res, 32'd0);
      chk("reset_state", {30'd0, state_dbg}, 32'd0);
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("post_reset_res", res, 32'd0);
      chk("post_reset_busy", {31'd0, busy}, 32'd0);

      start(OP_DIV, 32'd100, 32'd7);
      chk("div_busy_calc", {31'd0, busy}, 32'd1);
      chk("div_state_calc", {30'd0, state_dbg}, 32'd1);
      wait_done("div_100_7", 32'd14, 0, 1'b0);
      start(OP_REM, 32'd100, 32'd7);
      wait_done("rem_100_7", 32'd2, 0, 1'b0);

      start(OP_REM, 32'hFFFFFFF9, 32'd2);
      wait_done("rem_m7_2", 32'hFFFFFFFF, 0, 1'b0);
      start(OP_DIV, 32'hFFFFFFF9, 32'd2);
      wait_done("div_m7_2", 32'hFFFFFFFD, 0, 1'b0);
      start(OP_DIV, 32'd7, 32'hFFFFFFFE);
      wait_done("div_7_m2", 32'hFFFFFFFD, 0, 1'b0);
      start(OP_REM, 32'd7, 32'hFFFFFFFE);
      wait_done("rem_7_m2", 32'd1, 0, 1'b0);

      start(OP_DIVU, 32'd5, 32'd0);
      wait_done("divu_5_0", 32'hFFFFFFFF, 0, 1'b0);
      start(OP_REMU, 32'd5, 32'd0);
      wait_done("remu_5_0", 32'd5, 0, 1'b0);
      start(OP_DIV, 32'hFFFFFFF9, 32'd0);
      wait_done("div_m7_0", 32'hFFFFFFFF, 0, 1'b0);
      start(OP_REM, 32'hFFFFFFF9, 32'd0);
      wait_done("rem_m7_0", 32'hFFFFFFF9, 0, 1'b0);

      start(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_done("div_ovf", 32'h80000000, 0, 1'b0);
      start(OP_REM, 32'h80000000, 32'hFFFFFFFF);
      wait_done("rem_ovf", 32'd0, 0, 1'b0);

      start(OP_DIVU, 32'hFFFFFFFF, 32'd2);
      wait_done("divu_max_2", 32'h7FFFFFFF, 0, 1'b0);
      start(OP_REMU, 32'hFFFFFFFF, 32'd2);
      wait_done("remu_max_2", 32'd1, 0, 1'b0);
      start(OP_DIV, 32'hFFFFFFFF, 32'd2);
      wait_done("div_m1_2", 32'd0, 0, 1'b0);

      start(OP_DIV, 32'd100, 32'd7);
      wait_done("div_reissue", 32'd14, 10, 1'b0);
      start(OP_DIVU, 32'd9, 32'd3);
      wait_done("divu_en_at_done", 32'd3, 0, 1'b1);

      start(OP_DIVU, 32'd1000, 32'd10);
      wait_done("divu_before_rst", 32'd100, 0, 1'b0);
      start(OP_DIVU, 32'd12345, 32'd7);
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_abort_finish", {31'd0, finish}, 32'd0);
      chk("rst_abort_res", res, 32'd0);
      chk("rst_abort_busy", {31'd0, busy}, 32'd0);
      chk("rst_abort_state", {30'd0, state_dbg}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      begin
         int pulses;
         pulses = 0;
         for (int i = 0; i < 40; i++) begin
            if (finish) pulses++;
            @(posedge clk);
            #1;
         end
         chk("rst_no_finish", 32'(pulses), 32'd0);
         chk("rst_res_stays_zero", res, 32'd0);
      end
      start(OP_DIVU, 32'd9, 32'd3);
      wait_done("divu_9_3_after_rst", 32'd3, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
